// File: rtl/reg_bank.sv
// reg_bank: parametrised register file with two read ports, a write-target
// read-back port, unsigned compare flags, and load/immediate/move/inc/dec
// write modes plus a two-cycle swap sequenced by a small FSM.
module reg_bank #(
   parameter int DW = 8,   // register data width
   parameter int PW = 4,   // address width; depth = 2**PW
   parameter int IW = 6    // immediate width, IW <= DW
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          WriteEn,
   input  logic [2:0]    Mode,
   input  logic [PW-1:0] Waddr,
   input  logic [PW-1:0] Src,
   input  logic [DW-1:0] DataIn,
   input  logic [IW-1:0] ImmediateVal,
   input  logic [PW-1:0] RaddrA,
   input  logic [PW-1:0] RaddrB,
   output logic [DW-1:0] DataOutA,
   output logic [DW-1:0] DataOutB,
   output logic [DW-1:0] DataOutC,
   output logic          Eq,
   output logic          Gt,
   output logic          Lt,
   output logic          Carry,
   output logic          Busy
);

   localparam int DEPTH = 1 << PW;

   localparam logic [2:0] MODE_LOAD = 3'd0;
   localparam logic [2:0] MODE_IMM  = 3'd1;
   localparam logic [2:0] MODE_MOVE = 3'd2;
   localparam logic [2:0] MODE_SWAP = 3'd3;
   localparam logic [2:0] MODE_INC  = 3'd4;
   localparam logic [2:0] MODE_DEC  = 3'd5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWAP2 = 1'b1
   } state_t;

   // Storage is a flop array: all three read ports are combinational.
   logic [DW-1:0] r_regs [DEPTH];
   logic [DW-1:0] r_tmp;
   logic [PW-1:0] r_src_q;
   logic          r_carry;
   state_t        r_state;

   state_t        w_state_next;
   logic          w_wr_en;
   logic [PW-1:0] w_wr_addr;
   logic [DW-1:0] w_wr_data;
   logic          w_carry_next;
   logic [DW-1:0] w_tmp_next;
   logic [PW-1:0] w_src_q_next;
   logic [DW-1:0] w_cur_val;
   logic [DW-1:0] w_src_val;

   assign w_cur_val = r_regs[Waddr];
   assign w_src_val = r_regs[Src];

   assign DataOutA = r_regs[RaddrA];
   assign DataOutB = r_regs[RaddrB];
   assign DataOutC = r_regs[Waddr];

   assign Eq    = (DataOutA == DataOutB);
   assign Gt    = (DataOutA >  DataOutB);
   assign Lt    = (DataOutA <  DataOutB);
   assign Carry = r_carry;
   assign Busy  = (r_state == ST_SWAP2);

   // Decode the requested operation into a single write port plus carry/FSM updates.
   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      w_wr_addr    = Waddr;
      w_wr_data    = DataIn;
      w_carry_next = r_carry;
      w_tmp_next   = r_tmp;
      w_src_q_next = r_src_q;
      case (r_state)
         ST_IDLE: begin
            if (WriteEn) begin
               case (Mode)
                  MODE_LOAD: begin
                     w_wr_en   = 1'b1;
                     w_wr_data = DataIn;
                  end
                  MODE_IMM: begin
                     w_wr_en   = 1'b1;
                     w_wr_data = DW'(ImmediateVal);
                  end
                  MODE_MOVE: begin
                     w_wr_en   = 1'b1;
                     w_wr_data = w_src_val;
                  end
                  MODE_SWAP: begin
                     // First half: destination takes the source value now,
                     // old destination parks in r_tmp for the second edge.
                     w_wr_en      = 1'b1;
                     w_wr_data    = w_src_val;
                     w_tmp_next   = w_cur_val;
                     w_src_q_next = Src;
                     w_state_next = ST_SWAP2;
                  end
                  MODE_INC: begin
                     w_wr_en = 1'b1;
                     {w_carry_next, w_wr_data} = {1'b0, w_cur_val} + (DW+1)'(1);
                  end
                  MODE_DEC: begin
                     w_wr_en      = 1'b1;
                     w_wr_data    = w_cur_val - DW'(1);
                     w_carry_next = (w_cur_val == '0);
                  end
                  default: begin
                     // Reserved codes: no write, no carry change.
                     w_wr_en = 1'b0;
                  end
               endcase
            end
         end
         ST_SWAP2: begin
            // Second half uses only latched values; live inputs are ignored.
            w_wr_en      = 1'b1;
            w_wr_addr    = r_src_q;
            w_wr_data    = r_tmp;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state, swap scratch and carry registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_tmp   <= '0;
         r_src_q <= '0;
         r_carry <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tmp   <= w_tmp_next;
         r_src_q <= w_src_q_next;
         r_carry <= w_carry_next;
      end
   end

   // Register file write; reset clears every entry, which also aborts a pending swap.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (Reset) begin
            r_regs[i] <= '0;
         end else if (w_wr_en && (w_wr_addr == PW'(i))) begin
            r_regs[i] <= w_wr_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed test-plan steps followed by randomized traffic, all
// checked against a behavioural model of the register bank held in arrays.
module tb_reg_bank;

   localparam int DW = 8;
   localparam int PW = 4;
   localparam int IW = 6;
   localparam int DEPTH = 16;

   logic          Clk;
   logic          Reset;
   logic          WriteEn;
   logic [2:0]    Mode;
   logic [PW-1:0] Waddr;
   logic [PW-1:0] Src;
   logic [DW-1:0] DataIn;
   logic [IW-1:0] ImmediateVal;
   logic [PW-1:0] RaddrA;
   logic [PW-1:0] RaddrB;
   logic [DW-1:0] DataOutA;
   logic [DW-1:0] DataOutB;
   logic [DW-1:0] DataOutC;
   logic          Eq;
   logic          Gt;
   logic          Lt;
   logic          Carry;
   logic          Busy;

   reg_bank #(.DW(DW), .PW(PW), .IW(IW)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .WriteEn(WriteEn),
      .Mode(Mode),
      .Waddr(Waddr),
      .Src(Src),
      .DataIn(DataIn),
      .ImmediateVal(ImmediateVal),
      .RaddrA(RaddrA),
      .RaddrB(RaddrB),
      .DataOutA(DataOutA),
      .DataOutB(DataOutB),
      .DataOutC(DataOutC),
      .Eq(Eq),
      .Gt(Gt),
      .Lt(Lt),
      .Carry(Carry),
      .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural model: register contents, carry, and a pending-swap record.
   int unsigned m_regs [DEPTH];
   int unsigned m_carry;
   bit          m_pending;
   int unsigned m_pend_addr;
   int unsigned m_pend_val;

   int n_assert;
   int n_fail;
   int n_step;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      int unsigned old_w;
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) m_regs[i] = 0;
         m_carry   = 0;
         m_pending = 0;
      end else if (m_pending) begin
         m_regs[m_pend_addr] = m_pend_val;
         m_pending = 0;
      end else if (WriteEn) begin
         old_w = m_regs[Waddr];
         case (Mode)
            3'd0: m_regs[Waddr] = DataIn;
            3'd1: m_regs[Waddr] = ImmediateVal;
            3'd2: m_regs[Waddr] = m_regs[Src];
            3'd3: begin
               m_pend_val  = old_w;
               m_pend_addr = Src;
               m_regs[Waddr] = m_regs[Src];
               m_pending = 1;
            end
            3'd4: begin
               m_regs[Waddr] = (old_w + 1) % 256;
               m_carry = (old_w == 255) ? 1 : 0;
            end
            3'd5: begin
               m_regs[Waddr] = (old_w + 255) % 256;
               m_carry = (old_w == 0) ? 1 : 0;
            end
            default: ;
         endcase
      end
   endtask

   // Compare every visible output against the model.
   task automatic check_all();
      int unsigned a;
      int unsigned b;
      a = m_regs[RaddrA];
      b = m_regs[RaddrB];
      chk("DataOutA", 32'(DataOutA), a);
      chk("DataOutB", 32'(DataOutB), b);
      chk("DataOutC", 32'(DataOutC), m_regs[Waddr]);
      chk("Eq", 32'(Eq), (a == b) ? 1 : 0);
      chk("Gt", 32'(Gt), (a > b) ? 1 : 0);
      chk("Lt", 32'(Lt), (a < b) ? 1 : 0);
      chk("Carry", 32'(Carry), m_carry);
      chk("Busy", 32'(Busy), m_pending ? 1 : 0);
   endtask

   // One transaction: drive inputs, take an edge, then check at the falling edge.
   task automatic step(input logic rst, input logic we, input logic [2:0] mode,
                       input logic [3:0] wa, input logic [3:0] sa,
                       input logic [7:0] din, input logic [5:0] imm,
                       input logic [3:0] ra, input logic [3:0] rb);
      Reset = rst; WriteEn = we; Mode = mode; Waddr = wa; Src = sa;
      DataIn = din; ImmediateVal = imm; RaddrA = ra; RaddrB = rb;
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check_all();
      n_step++;
      $display("step %0d rst=%0b we=%0b mode=%0d wa=%0d src=%0d din=%02h imm=%02h -> A=%02h B=%02h C=%02h carry=%0b busy=%0b",
               n_step, rst, we, mode, wa, sa, din, imm, DataOutA, DataOutB, DataOutC, Carry, Busy);
   endtask

   initial begin
      n_assert = 0; n_fail = 0; n_step = 0;
      for (int i = 0; i < DEPTH; i++) m_regs[i] = 0;
      m_carry = 0; m_pending = 0; m_pend_addr = 0; m_pend_val = 0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_eq", 32'(Eq), 1);

      // IMM zero-extension and compare flags
      step(0, 1, 1, 5, 0, 8'h00, 6'h3F, 5, 0);
      chk("imm_C", 32'(DataOutC), 32'h3F);
      chk("imm_gt", 32'(Gt), 1);

      // INC/DEC carry and borrow
      step(0, 1, 0, 2, 0, 8'hFF, 0, 2, 0);
      step(0, 1, 4, 2, 0, 0, 0, 2, 0);
      chk("inc_wrap", 32'(DataOutA), 32'h00);
      chk("inc_carry", 32'(Carry), 1);
      step(0, 1, 5, 2, 0, 0, 0, 2, 0);
      chk("dec_borrow_val", 32'(DataOutA), 32'hFF);
      chk("dec_borrow", 32'(Carry), 1);
      step(0, 1, 5, 2, 0, 0, 0, 2, 0);
      chk("dec_val", 32'(DataOutA), 32'hFE);
      chk("dec_carry", 32'(Carry), 0);

      // SWAP R3 <-> R7
      step(0, 1, 0, 3, 0, 8'hA5, 0, 3, 7);
      step(0, 1, 0, 7, 0, 8'h5A, 0, 3, 7);
      step(0, 1, 3, 3, 7, 0, 0, 3, 7);
      chk("swap_e1_r3", 32'(DataOutA), 32'h5A);
      chk("swap_e1_r7", 32'(DataOutB), 32'h5A);
      chk("swap_e1_busy", 32'(Busy), 1);
      // LOAD R9 presented while busy must be ignored
      step(0, 1, 0, 9, 0, 8'h11, 0, 9, 7);
      chk("busy_load_ignored", 32'(DataOutA), 32'h00);
      chk("swap_e2_r7", 32'(DataOutB), 32'hA5);
      chk("swap_e2_busy", 32'(Busy), 0);

      // Reset aborts a swap in progress; set Carry first so the clear is visible
      step(0, 1, 0, 8, 0, 8'hFF, 0, 8, 0);
      step(0, 1, 4, 8, 0, 0, 0, 8, 0);
      step(0, 1, 0, 4, 0, 8'h10, 0, 4, 6);
      step(0, 1, 0, 6, 0, 8'h20, 0, 4, 6);
      step(0, 1, 3, 4, 6, 0, 0, 4, 6);
      step(1, 0, 0, 4, 6, 0, 0, 4, 6);
      chk("rst_swap_r4", 32'(DataOutA), 0);
      chk("rst_swap_r6", 32'(DataOutB), 0);
      chk("rst_swap_busy", 32'(Busy), 0);
      chk("rst_swap_carry", 32'(Carry), 0);

      // MOVE and reserved mode
      step(0, 1, 0, 3, 0, 8'hC3, 0, 1, 3);
      step(0, 1, 2, 1, 3, 0, 0, 1, 3);
      chk("move_r1", 32'(DataOutA), 32'hC3);
      step(0, 1, 6, 1, 3, 8'h77, 6'h15, 1, 3);
      chk("reserved_r1", 32'(DataOutA), 32'hC3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)),
              4'($urandom), 4'($urandom),
              8'($urandom), 6'($urandom),
              4'($urandom), 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
